key_debounce_toggle: RTL and testbench

KEY_DEBOUNCE_TOGGLE -- requirements
Module: key_debounce_toggle

---
 rtl/key_debounce_toggle.sv | 82 ++++++++
 tb/tb_key_debounce_toggle.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/key_debounce_toggle.sv
// Multi-channel key debouncer: active-low raw pins in, debounced level,
// press/release pulses and a press-driven toggle level out.
// The release pulse output is named "released" because "release" is a
// reserved word in SystemVerilog.
module key_debounce_toggle #(
   parameter int unsigned N_KEYS = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] down,
   output logic [N_KEYS-1:0] press,
   output logic [N_KEYS-1:0] released,
   output logic [N_KEYS-1:0] toggle,
   output logic              vcc_for_keys
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_KEYS-1:0] sync_q1;
   logic [N_KEYS-1:0] sync_q2;
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [CNT_W-1:0]  cnt_d [N_KEYS];
   logic [N_KEYS-1:0] down_d;
   logic [N_KEYS-1:0] press_d;
   logic [N_KEYS-1:0] released_d;
   logic [N_KEYS-1:0] toggle_d;

   // Pull-up/common supply for the key matrix, live even during reset.
   assign vcc_for_keys = 1'b1;

   // Per-channel qualification: count while the synced level disagrees with
   // the accepted level, accept on the cycle after the counter saturates.
   always_comb begin
      down_d     = down;
      press_d    = '0;
      released_d = '0;
      toggle_d   = toggle;
      for (int i = 0; i < int'(N_KEYS); i++) begin
         cnt_d[i] = '0;
         if (sync_q2[i] != down[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               down_d[i]     = sync_q2[i];
               press_d[i]    = sync_q2[i];
               released_d[i] = ~sync_q2[i];
               if (sync_q2[i]) begin
                  toggle_d[i] = ~toggle[i];
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Synchronizer, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1  <= '0;
         sync_q2  <= '0;
         down     <= '0;
         press    <= '0;
         released <= '0;
         toggle   <= '0;
         for (int i = 0; i < int'(N_KEYS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync_q1  <= ~key_n;
         sync_q2  <= sync_q1;
         down     <= down_d;
         press    <= press_d;
         released <= released_d;
         toggle   <= toggle_d;
         for (int i = 0; i < int'(N_KEYS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_key_debounce_toggle.sv
// Directed bench for key_debounce_toggle with CNT_W = 2 (4-cycle qualification).
module tb_key_debounce_toggle;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key_n = 3'b111;
   logic [2:0] down, press, released, toggle;
   logic       vcc_for_keys;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       rst;
      logic [2:0] key_n;
      logic [2:0] down;
      logic [2:0] press;
      logic [2:0] rel;
      logic [2:0] tog;
   } vec_t;

   vec_t vecs[$];

   key_debounce_toggle #(.N_KEYS(3), .CNT_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n),
      .down         (down),
      .press        (press),
      .released     (released),
      .toggle       (toggle),
      .vcc_for_keys (vcc_for_keys)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input logic r, input logic [2:0] kn);
      @(negedge clk);
      rst   = r;
      key_n = kn;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [2:0] kn, input logic [2:0] d,
                      input logic [2:0] p, input logic [2:0] rl, input logic [2:0] t,
                      input int n);
      vec_t v;
      v.rst = r; v.key_n = kn; v.down = d; v.press = p; v.rel = rl; v.tog = t;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   initial begin
      int np;
      int nr;
      logic tog_mid;

      // Reset, clean press on key 0, its release, then all keys at once.
      add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2);
      add(1'b0, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 5);
      add(1'b0, 3'b110, 3'b001, 3'b001, 3'b000, 3'b001, 1);
      add(1'b0, 3'b110, 3'b001, 3'b000, 3'b000, 3'b001, 1);
      add(1'b0, 3'b111, 3'b001, 3'b000, 3'b000, 3'b001, 5);
      add(1'b0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 1);
      add(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 1);
      add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5);
      add(1'b0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b111, 1);
      add(1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111, 2);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].key_n);
         chk($sformatf("vec%0d.down", i), down, vecs[i].down);
         chk($sformatf("vec%0d.press", i), press, vecs[i].press);
         chk($sformatf("vec%0d.release", i), released, vecs[i].rel);
         chk($sformatf("vec%0d.toggle", i), toggle, vecs[i].tog);
         chk($sformatf("vec%0d.vcc", i), {2'b00, vcc_for_keys}, 3'b001);
      end

      // Bounce on key 0: low 3, high 1, then low held.
      step(1'b1, 3'b111);
      step(1'b1, 3'b111);
      for (int c = 0; c < 10; c++) begin
         step(1'b0, {2'b11, (c == 3)});
         if (c < 9) begin
            chk($sformatf("bounce.c%0d.down", c), down, 3'b000);
            chk($sformatf("bounce.c%0d.press", c), press, 3'b000);
         end else begin
            chk("bounce.accept.down", down, 3'b001);
            chk("bounce.accept.press", press, 3'b001);
            chk("bounce.accept.toggle", toggle, 3'b001);
         end
      end

      // Press / release / press on key 1, each held 10 cycles.
      step(1'b1, 3'b111);
      step(1'b1, 3'b111);
      np = 0;
      nr = 0;
      tog_mid = 1'b0;
      for (int c = 0; c < 34; c++) begin
         step(1'b0, (c < 10 || c >= 20) ? 3'b101 : 3'b111);
         np += int'(press[1]);
         nr += int'(released[1]);
         if (c == 14) tog_mid = toggle[1];
      end
      chk("ppr.press_count", 3'(np), 3'd2);
      chk("ppr.release_count", 3'(nr), 3'd1);
      chk("ppr.toggle_mid", {2'b00, tog_mid}, 3'b001);
      chk("ppr.toggle_end", toggle, 3'b000);
      chk("ppr.down_end", down, 3'b010);

      // Reset in the middle of qualification on key 2, key held throughout.
      step(1'b1, 3'b111);
      for (int c = 0; c < 4; c++) step(1'b0, 3'b011);
      step(1'b1, 3'b011);
      chk("rstmid.down", down, 3'b000);
      chk("rstmid.press", press, 3'b000);
      chk("rstmid.release", released, 3'b000);
      chk("rstmid.toggle", toggle, 3'b000);
      chk("rstmid.vcc", {2'b00, vcc_for_keys}, 3'b001);
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 3'b011);
         if (c < 5) begin
            chk($sformatf("rstmid.c%0d.press", c), press, 3'b000);
            chk($sformatf("rstmid.c%0d.down", c), down, 3'b000);
         end else begin
            chk("rstmid.accept.press", press, 3'b100);
            chk("rstmid.accept.down", down, 3'b100);
            chk("rstmid.accept.toggle", toggle, 3'b100);
         end
      end
      step(1'b0, 3'b011);
      chk("rstmid.press_one_cycle", press, 3'b000);
      chk("rstmid.vcc_end", {2'b00, vcc_for_keys}, 3'b001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
